// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one combinational 16-bit ALU between two valid/ready
//               requesters. The granted port's operands are driven onto the
//               ALU. The result is registered into a one-entry response buffer
//               that is tagged with the requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int FIXED_PRIO = 0,   // 0 = round-robin, 1 = port 0 always wins
    parameter int DW         = 16   // datapath width, only 16 is supported
) (
    input  logic          clk,
    input  logic          rst,
    // requester 0
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [4:0]    req0_opcode,
    input  logic [1:0]    req0_funct,
    input  logic [DW-1:0] req0_rs,
    input  logic [DW-1:0] req0_rt,
    input  logic [DW-1:0] req0_pc,
    input  logic [7:0]    req0_imm,
    // requester 1
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [4:0]    req1_opcode,
    input  logic [1:0]    req1_funct,
    input  logic [DW-1:0] req1_rs,
    input  logic [DW-1:0] req1_rt,
    input  logic [DW-1:0] req1_pc,
    input  logic [7:0]    req1_imm,
    // shared ALU
    output logic [4:0]    alu_opcode,
    output logic [1:0]    alu_funct,
    output logic [DW-1:0] alu_rs,
    output logic [DW-1:0] alu_rt,
    output logic [DW-1:0] alu_pc,
    output logic [7:0]    alu_imm,
    input  logic [DW-1:0] alu_res,
    // response buffer
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_res,
    output logic          rsp_id
);

    // The buffer occupancy is the state. FULL means that rsp_valid is high.
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t r_state;
    logic   r_ptr;      // port favoured on a tie (0 or 1)
    logic   w_slot_free;
    logic   w_both;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_gnt;

    // A result can be accepted when the buffer is empty or is being drained.
    assign w_slot_free = (r_state == S_EMPTY) || rsp_ready;
    assign w_both      = req0_valid && req1_valid;

    // Grant selection. Port 0 wins a tie under fixed priority. Otherwise the pointer decides.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && w_slot_free) begin
            if (w_both) begin
                if ((FIXED_PRIO != 0) || !r_ptr) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_gnt      = w_gnt0 || w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Route the granted port's operands to the ALU. All outputs are zero while idle.
    always_comb begin
        alu_opcode = '0;
        alu_funct  = '0;
        alu_rs     = '0;
        alu_rt     = '0;
        alu_pc     = '0;
        alu_imm    = '0;
        if (w_gnt0) begin
            alu_opcode = req0_opcode;
            alu_funct  = req0_funct;
            alu_rs     = req0_rs;
            alu_rt     = req0_rt;
            alu_pc     = req0_pc;
            alu_imm    = req0_imm;
        end else if (w_gnt1) begin
            alu_opcode = req1_opcode;
            alu_funct  = req1_funct;
            alu_rs     = req1_rs;
            alu_rt     = req1_rt;
            alu_pc     = req1_pc;
            alu_imm    = req1_imm;
        end
    end

    // Buffer FSM, result capture and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            rsp_res <= '0;
            rsp_id  <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_gnt) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    // A drain with no new grant empties the buffer. A stall or a reload keeps it full.
                    if (rsp_ready && !w_gnt) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
            if (w_gnt) begin
                rsp_res <= alu_res;
                rsp_id  <= w_gnt1;
                // After a grant, favour the other port on the next tie.
                r_ptr   <= w_gnt0;
            end
        end
    end

    assign rsp_valid = (r_state == S_FULL);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed bench for alu_share_arbiter. It drives one
//               round-robin instance and one fixed-priority instance from
//               shared request inputs. A small ALU model closes each loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_opcode, req1_opcode;
    logic [1:0]  req0_funct, req1_funct;
    logic [15:0] req0_rs, req0_rt, req0_pc, req1_rs, req1_rt, req1_pc;
    logic [7:0]  req0_imm, req1_imm;
    logic        rsp_ready;

    // round-robin instance (a) and fixed-priority instance (b)
    logic        req0_ready_a, req1_ready_a, rsp_valid_a, rsp_id_a;
    logic [4:0]  alu_opcode_a;
    logic [1:0]  alu_funct_a;
    logic [15:0] alu_rs_a, alu_rt_a, alu_pc_a, alu_res_a, rsp_res_a;
    logic [7:0]  alu_imm_a;
    logic        req0_ready_b, req1_ready_b, rsp_valid_b, rsp_id_b;
    logic [4:0]  alu_opcode_b;
    logic [1:0]  alu_funct_b;
    logic [15:0] alu_rs_b, alu_rt_b, alu_pc_b, alu_res_b, rsp_res_b;
    logic [7:0]  alu_imm_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Reduced ALU: opcode 11011 is add/sub/xor/and selected by funct, 01001 is addi
    // with a sign-extended imm. Any other opcode returns rs ^ imm ^ pc.
    function automatic logic [15:0] alu_model(input logic [4:0] op, input logic [1:0] f,
                                              input logic [15:0] rs, input logic [15:0] rt,
                                              input logic [15:0] pc, input logic [7:0] imm);
        logic [15:0] res;
        case (op)
            5'b11011: begin
                case (f)
                    2'b00:   res = rs + rt;
                    2'b01:   res = rs - rt;
                    2'b10:   res = rs ^ rt;
                    default: res = rs & rt;
                endcase
            end
            5'b01001: res = rs + {{8{imm[7]}}, imm};
            default:  res = rs ^ {8'h00, imm} ^ pc;
        endcase
        return res;
    endfunction

    assign alu_res_a = alu_model(alu_opcode_a, alu_funct_a, alu_rs_a, alu_rt_a, alu_pc_a, alu_imm_a);
    assign alu_res_b = alu_model(alu_opcode_b, alu_funct_b, alu_rs_b, alu_rt_b, alu_pc_b, alu_imm_b);

    alu_share_arbiter #(.FIXED_PRIO(0), .DW(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready_a), .req0_opcode(req0_opcode),
        .req0_funct(req0_funct), .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_pc(req0_pc),
        .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready_a), .req1_opcode(req1_opcode),
        .req1_funct(req1_funct), .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_pc(req1_pc),
        .req1_imm(req1_imm),
        .alu_opcode(alu_opcode_a), .alu_funct(alu_funct_a), .alu_rs(alu_rs_a), .alu_rt(alu_rt_a),
        .alu_pc(alu_pc_a), .alu_imm(alu_imm_a), .alu_res(alu_res_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_res(rsp_res_a), .rsp_id(rsp_id_a)
    );

    alu_share_arbiter #(.FIXED_PRIO(1), .DW(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready_b), .req0_opcode(req0_opcode),
        .req0_funct(req0_funct), .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_pc(req0_pc),
        .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready_b), .req1_opcode(req1_opcode),
        .req1_funct(req1_funct), .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_pc(req1_pc),
        .req1_imm(req1_imm),
        .alu_opcode(alu_opcode_b), .alu_funct(alu_funct_b), .alu_rs(alu_rs_b), .alu_rt(alu_rt_b),
        .alu_pc(alu_pc_b), .alu_imm(alu_imm_b), .alu_res(alu_res_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_res(rsp_res_b), .rsp_id(rsp_id_b)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_opcode = '0; req0_funct = '0;
        req0_rs = '0; req0_rt = '0; req0_pc = '0; req0_imm = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_funct = '0;
        req1_rs = '0; req1_rt = '0; req1_pc = '0; req1_imm = '0;
        tick;
        tick;

        // reset state: ready stays low while rst is high
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", req0_ready_a, 16'd0);
        check("rst_valid",  rsp_valid_a,  16'd0);
        check("rst_res",    rsp_res_a,    16'h0000);
        check("rst_id",     rsp_id_a,     16'd0);
        req0_valid = 1'b0;
        rst = 1'b0;
        tick;

        // 1: single add request
        req0_valid = 1'b1; req0_opcode = 5'b11011; req0_funct = 2'b00;
        req0_rs = 16'h0003; req0_rt = 16'h0004;
        #1;
        check("t1_ready0", req0_ready_a, 16'd1);
        check("t1_aluop",  alu_opcode_a, 16'h001b);
        check("t1_alurs",  alu_rs_a,     16'h0003);
        tick;
        req0_valid = 1'b0;
        check("t1_valid", rsp_valid_a, 16'd1);
        check("t1_res",   rsp_res_a,   16'h0007);
        check("t1_id",    rsp_id_a,    16'd0);
        tick;
        check("t1_drain",   rsp_valid_a, 16'd0);
        check("t1_reshold", rsp_res_a,   16'h0007);

        // 2 and 4: dual requests from reset
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req0_valid = 1'b1; req0_opcode = 5'b01001; req0_funct = 2'b00;
        req0_rs = 16'h0001; req0_rt = 16'h0000; req0_imm = 8'h05;
        req1_valid = 1'b1; req1_opcode = 5'b11011; req1_funct = 2'b10;
        req1_rs = 16'h00F0; req1_rt = 16'h0F0F;
        #1;
        check("t2_ready0", req0_ready_a, 16'd1);
        check("t2_ready1", req1_ready_a, 16'd0);
        check("t2_aluimm", alu_imm_a,    16'h0005);
        tick;
        check("t2_res0", rsp_res_a, 16'h0006);
        check("t2_id0",  rsp_id_a,  16'd0);
        #1;
        check("t2_ready1b", req1_ready_a, 16'd1);
        check("t2_ready0b", req0_ready_a, 16'd0);
        tick;
        check("t2_res1", rsp_res_a, 16'h0FFF);
        check("t2_id1",  rsp_id_a,  16'd1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_rr_ready0", req0_ready_a, i[0] ? 16'd0 : 16'd1);
            check("t4_fp_ready0", req0_ready_b, 16'd1);
            check("t4_fp_ready1", req1_ready_b, 16'd0);
            tick;
            check("t2_rr_id",  rsp_id_a,  i[0] ? 16'd1 : 16'd0);
            check("t2_rr_res", rsp_res_a, i[0] ? 16'h0FFF : 16'h0006);
            check("t4_fp_id",  rsp_id_b,  16'd0);
            check("t4_fp_res", rsp_res_b, 16'h0006);
        end

        // 3: backpressure with both ports valid
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_ready0", req0_ready_a, 16'd0);
            check("t3_ready1", req1_ready_a, 16'd0);
            tick;
            check("t3_valid", rsp_valid_a, 16'd1);
            check("t3_res",   rsp_res_a,   16'h0FFF);
            check("t3_id",    rsp_id_a,    16'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("t3_resume0", req0_ready_a, 16'd1);
        tick;
        check("t3_res_after", rsp_res_a, 16'h0006);
        check("t3_id_after",  rsp_id_a,  16'd0);

        // 5: reset while full and req1 waiting
        req0_valid = 1'b0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_ready_in_rst", req1_ready_a, 16'd0);
        check("t5_valid_pre",    rsp_valid_a,  16'd1);
        tick;
        rst = 1'b0;
        rsp_ready = 1'b1;
        check("t5_valid", rsp_valid_a, 16'd0);
        check("t5_res",   rsp_res_a,   16'h0000);
        check("t5_id",    rsp_id_a,    16'd0);
        req0_valid = 1'b1;
        #1;
        check("t5_ready0", req0_ready_a, 16'd1);
        check("t5_ready1", req1_ready_a, 16'd0);
        tick;
        check("t5_res0", rsp_res_a, 16'h0006);
        check("t5_id0",  rsp_id_a,  16'd0);

        // illegal opcode passes straight through with the same latency
        req0_valid = 1'b0;
        req1_opcode = 5'b11111; req1_funct = 2'b00;
        req1_rs = 16'h1200; req1_rt = 16'h0000; req1_pc = 16'h0005; req1_imm = 8'h34;
        #1;
        check("ill_ready1", req1_ready_a, 16'd1);
        check("ill_aluop",  alu_opcode_a, 16'h001f);
        check("ill_alupc",  alu_pc_a,     16'h0005);
        tick;
        req1_valid = 1'b0;
        check("ill_valid", rsp_valid_a, 16'd1);
        check("ill_res",   rsp_res_a,   16'h1231);
        check("ill_id",    rsp_id_a,    16'd1);

        // 6: idle
        #1;
        check("t6_aluop",  alu_opcode_a, 16'h0000);
        check("t6_alurs",  alu_rs_a,     16'h0000);
        check("t6_aluimm", alu_imm_a,    16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t6_valid", rsp_valid_a, 16'd0);
            check("t6_alupc", alu_pc_a,    16'h0000);
        end
        check("t6_reshold", rsp_res_a, 16'h1231);
        check("t6_idhold",  rsp_id_a,  16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 16-bit `alu` instance between two requesters, e.g. the execute stage (port 0) and the branch/compare or self-test path (port 1).
- Arbitrates with valid/ready handshakes and drives the granted requester's operands onto the ALU inputs.
- Registers the ALU result into a one-entry response buffer, tagged with the requester ID, and holds it under backpressure.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins.
- DW, 16: datapath width for Rs, Rt, Pc and result; only 16 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_opcode  in  5  port 0 ALU OpCode
- req0_funct  in  2  port 0 funct
- req0_rs, req0_rt, req0_pc  in  16 each  port 0 operands
- req0_imm  in  8  port 0 immediate
- req1_valid, req1_ready, req1_opcode, req1_funct, req1_rs, req1_rt, req1_pc, req1_imm  as port 0, for port 1
- alu_opcode  out  5  to alu OpCode
- alu_funct  out  2  to alu funct
- alu_rs, alu_rt, alu_pc  out  16 each  to alu Rs, Rt, Pc
- alu_imm  out  8  to alu Imm
- alu_res  in  16  from alu res
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_res  out  16  registered ALU result
- rsp_id  out  1  requester that produced rsp_res

Behaviour:
- Reset values (rst high at posedge): rsp_valid=0, rsp_res=0, rsp_id=0, round-robin pointer = port 0 favoured.
- Reset mid-operation discards any buffered response.
- Buffer free condition: `slot_free = !rsp_valid || rsp_ready`.
- Grant: combinational, only when slot_free and at least one valid request.
  - Exactly one valid: that port wins.
  - Both valid, FIXED_PRIO=1: port 0 wins.
  - Both valid, FIXED_PRIO=0: the port favoured by the pointer wins.
- reqN_ready = grant to N. At most one ready is high per cycle. Ready is never high while rst is high.
- Handshake: a requester holds valid and its payload stable until it sees ready. Valid may not be withdrawn before acceptance. Acceptance occurs on the edge where valid && ready.
- ALU drive: combinational mux of the granted port's opcode, funct, rs, rt, pc and imm. With no grant, all alu_* outputs are 0.
- Capture: on an accepting edge, rsp_res <= alu_res, rsp_id <= granted port, rsp_valid <= 1.
- Latency and throughput: request accepted in cycle N gives rsp_valid high in cycle N+1. With rsp_ready held high, throughput is one result per cycle.
- Drain: rsp_valid && rsp_ready with no new grant gives rsp_valid <= 0. rsp_res and rsp_id keep their last value.
- Simultaneous drain and accept: the buffer reloads on the same edge and rsp_valid stays 1.
- Backpressure: while rsp_valid && !rsp_ready:
  - no grant;
  - rsp_res and rsp_id are held bit-stable;
  - pending requests wait.
- Pointer (FIXED_PRIO=0): after a grant to port N, the pointer favours the other port. It updates only on grants.
- Starvation bound: with both ports continuously valid, grants alternate 0,1,0,1.
- FSM (2 states, derived from rsp_valid):
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on drain with no grant.
  - FULL -> FULL on drain plus grant, or on stall.
  - EMPTY -> EMPTY when nothing is valid.
- The arbiter does not interpret opcodes. All 5-bit opcodes, including illegal ones, pass through unchanged and take the same 1-cycle latency.

Test Plan:
1. Single request, rsp_ready=1: req0 opcode=11011 funct=00 rs=0x0003 rt=0x0004 -> req0_ready=1 in cycle N; cycle N+1 rsp_valid=1, rsp_res=0x0007, rsp_id=0.
2. Simultaneous requests from reset, FIXED_PRIO=0: req0 addi opcode=01001 rs=0x0001 imm=0x05; req1 xor opcode=11011 funct=10 rs=0x00F0 rt=0x0F0F.
   - Cycle N+1: rsp 0x0006, id 0.
   - Cycle N+2: rsp 0x0FFF, id 1.
   - Continuous requests thereafter grant 0,1,0,1.
3. Backpressure: a response is buffered, then rsp_ready=0 for 3 cycles with both ports valid -> req*_ready=0 throughout; rsp_res and rsp_id unchanged; the first grant occurs in the cycle rsp_ready returns to 1.
4. FIXED_PRIO=1, both ports valid for 4 cycles -> only req0 is granted; req1_ready stays 0; four rsp_id=0 responses.
5. Reset mid-operation: rst=1 for one cycle while rsp_valid=1 and req1 is waiting -> next cycle rsp_valid=0, rsp_res=0, pointer favours port 0; a subsequent dual request grants port 0 first.
6. Idle: no valid requests for 5 cycles -> all alu_* outputs = 0; rsp_valid drops after drain and stays 0.
